// File: rtl/sdpram_pkg.sv
// Shared types, constants and the lane-parity helper for the banked simple dual-port RAM.
package sdpram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sdpram_state_t;

  localparam int COLL_READ_OLD    = 0;
  localparam int COLL_WRITE_FIRST = 1;

  // Widest word the parity helper accepts; callers zero-extend and keep the low lanes.
  localparam int PAR_MAX_DW = 1024;
  localparam int PAR_MAX_SW = PAR_MAX_DW / 8;

  function automatic logic [PAR_MAX_SW-1:0] byte_parity(input logic [PAR_MAX_DW-1:0] data);
    logic [PAR_MAX_SW-1:0] par;
    par = '0;
    for (int i = 0; i < PAR_MAX_SW; i++) begin
      par[i] = ^data[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/sdpram_init_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero, then raises init_done.
module sdpram_init_ctrl
  import sdpram_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output logic                  o_clr_we,
  output logic                  o_init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  sdpram_state_t         r_state;
  sdpram_state_t         w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_init_done;

  // State, counter and done flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_READY);
    end
  end

  // Next-state and clear-write decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_clr_we    = 1'b0;
    case (r_state)
      ST_INIT: begin
        o_clr_we = 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
        w_cnt_nxt   = r_cnt;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clr_addr  = r_cnt;
  assign o_init_done = r_init_done;

endmodule

// File: rtl/sdpram_banked_pipe.sv
// Simple dual-port RAM: byte-strobed write port A, pipelined read port B (latency 1 or 2),
// defined collision handling and a zeroing sequence after reset. Define SDPRAM_PARITY_EN for lane parity.
module sdpram_banked_pipe
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = COLL_READ_OLD,
  localparam int ADDR_WIDTH    = $clog2(MEM_DEPTH),
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STRB_WIDTH-1:0] wena,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  renb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid,
  output logic                  init_done
`ifdef SDPRAM_PARITY_EN
  ,
  output logic                  doutb_perr
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_clr_we;
  logic                  w_ready;

  sdpram_init_ctrl #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_ctrl (
    .clk         (clk),
    .rst         (rst),
    .o_clr_addr  (w_clr_addr),
    .o_clr_we    (w_clr_we),
    .o_init_done (w_ready)
  );

  assign init_done = w_ready;

  logic                  w_wa_inrange;
  logic                  w_rb_inrange;
  logic                  w_usr_we;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [STRB_WIDTH-1:0] w_wr_strb;
  logic [DATA_WIDTH-1:0] w_wr_data;

  assign w_wa_inrange = ({1'b0, addra} < DEPTH_EXT);
  assign w_rb_inrange = ({1'b0, addrb} < DEPTH_EXT);
  assign w_usr_we     = w_ready && (|wena) && w_wa_inrange;

  // Write-port mux: the clear sequencer owns the array until init completes
  always_comb begin
    w_mem_we  = 1'b0;
    w_wr_addr = '0;
    w_wr_strb = '0;
    w_wr_data = '0;
    if (w_clr_we) begin
      w_mem_we  = 1'b1;
      w_wr_addr = w_clr_addr;
      w_wr_strb = '1;
      w_wr_data = '0;
    end else begin
      w_mem_we  = w_usr_we;
      w_wr_addr = addra;
      w_wr_strb = wena;
      w_wr_data = dina;
    end
  end

  // Byte-lane array write
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_wr_strb[i]) begin
          mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
    end
  end

  logic                  w_rd_fire;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_rd_fire = w_ready && renb;
  // Only write-first mode forwards; an in-range user write implies addrb is in range too.
  assign w_fwd = (COLLISION_MODE == COLL_WRITE_FIRST) && w_usr_we && (addra == addrb);

  // Read-word selection with out-of-range zeroing and write-first lane merge
  always_comb begin
    w_rd_old  = '0;
    w_rd_data = '0;
    if (w_rb_inrange) begin
      w_rd_old = mem[addrb];
    end else begin
      w_rd_old = '0;
    end
    w_rd_data = w_rd_old;
    if (w_fwd) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wena[i]) begin
          w_rd_data[8*i +: 8] = dina[8*i +: 8];
        end else begin
          w_rd_data[8*i +: 8] = w_rd_old[8*i +: 8];
        end
      end
    end else begin
      w_rd_data = w_rd_old;
    end
  end

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  // First read stage; data only reloads on a read so doutb holds between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_s1_data <= w_rd_data;
      end else begin
        r_s1_data <= r_s1_data;
      end
    end
  end

`ifdef SDPRAM_PARITY_EN
  logic [STRB_WIDTH-1:0] r_par_mem [0:MEM_DEPTH-1];
  logic [PAR_MAX_SW-1:0] w_wr_par_full;
  logic [PAR_MAX_SW-1:0] w_rd_par_full;
  logic [STRB_WIDTH-1:0] w_rd_par_stored;
  logic [STRB_WIDTH-1:0] w_fwd_mask;
  logic                  w_rd_perr;
  logic                  r_s1_perr;

  assign w_wr_par_full = byte_parity(PAR_MAX_DW'(w_wr_data));
  assign w_rd_par_full = byte_parity(PAR_MAX_DW'(w_rd_data));

  // Parity array write, lane-aligned with the data write
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_wr_strb[i]) begin
          r_par_mem[w_wr_addr][i] <= w_wr_par_full[i];
        end
      end
    end
  end

  // Stored parity fetch; forwarded lanes are excluded from the compare
  always_comb begin
    w_rd_par_stored = '0;
    w_fwd_mask      = '0;
    if (w_rb_inrange) begin
      w_rd_par_stored = r_par_mem[addrb];
    end else begin
      w_rd_par_stored = '0;
    end
    if (w_fwd) begin
      w_fwd_mask = wena;
    end else begin
      w_fwd_mask = '0;
    end
  end

  assign w_rd_perr = |((w_rd_par_full[STRB_WIDTH-1:0] ^ w_rd_par_stored) & ~w_fwd_mask);

  // First-stage parity error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_perr <= 1'b0;
    end else if (w_rd_fire) begin
      r_s1_perr <= w_rd_perr;
    end else begin
      r_s1_perr <= r_s1_perr;
    end
  end
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      // Second read stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end else begin
            r_s2_data <= r_s2_data;
          end
        end
      end

      assign doutb_valid = r_s2_valid;
      assign doutb       = r_s2_data;

`ifdef SDPRAM_PARITY_EN
      logic r_s2_perr;

      // Second-stage parity error flag
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s2_perr <= 1'b0;
        end else if (r_s1_valid) begin
          r_s2_perr <= r_s1_perr;
        end else begin
          r_s2_perr <= r_s2_perr;
        end
      end

      assign doutb_perr = r_s2_perr;
`endif
    end else begin : g_lat1
      assign doutb_valid = r_s1_valid;
      assign doutb       = r_s1_data;
`ifdef SDPRAM_PARITY_EN
      assign doutb_perr  = r_s1_perr;
`endif
    end
  endgenerate

endmodule
